// File: rtl/register_file_pkg.sv
// register_file_pkg: shared datapath widths, index/word types and reset word.
package register_file_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 8;
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    localparam word_t RESET_WORD = 16'h0000;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: write, operand read and display ports of the register file.
interface register_file_if;
    import register_file_pkg::*;
    logic     p5;
    logic     write_enable;
    reg_idx_t write_addr;
    word_t    write_data;
    reg_idx_t read_addr_a;
    reg_idx_t read_addr_b;
    word_t    data_to_AR;
    word_t    data_to_BR;
    reg_idx_t dbg_addr;
    word_t    dbg_data;
    word_t    write_count;
    modport master (
        output p5, write_enable, write_addr, write_data, read_addr_a, read_addr_b, dbg_addr,
        input  data_to_AR, data_to_BR, dbg_data, write_count
    );
    modport slave (
        input  p5, write_enable, write_addr, write_data, read_addr_a, read_addr_b, dbg_addr,
        output data_to_AR, data_to_BR, dbg_data, write_count
    );
endinterface

// File: rtl/register_file_read_port.sv
// regfile_read_port: combinational register select with optional write-first bypass.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  word_t    regs [NUM_REGS],
    input  reg_idx_t addr,
    input  logic     wr_en,
    input  reg_idx_t wr_addr,
    input  word_t    wr_data,
    output word_t    data
);
    always_comb begin
        data = (BYPASS && wr_en && addr == wr_addr) ? wr_data : regs[addr];
    end
endmodule

// File: rtl/register_file.sv
// register_file: 8x16 register file, p5-qualified write port, two bypassing
// operand read ports, one committed-state display port and a write counter.
module register_file
    import register_file_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    register_file_if.slave rf
);
    if (NUM_REGS != 2**ADDR_WIDTH) begin : g_bad_size
        $error("register_file: NUM_REGS must equal 2**ADDR_WIDTH");
    end

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];
    word_t write_count_q, write_count_d;
    logic  commit;

    // Gated by reset so a held reset also suppresses the bypass path.
    always_comb begin
        commit = reset && rf.p5 && rf.write_enable;
    end

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[rf.write_addr] = rf.write_data;
            write_count_d         = write_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            foreach (regs_q[i]) regs_q[i] <= RESET_WORD;
            write_count_q <= RESET_WORD;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    regfile_read_port #(.BYPASS(1'b1)) u_port_a (
        .regs(regs_q), .addr(rf.read_addr_a), .wr_en(commit),
        .wr_addr(rf.write_addr), .wr_data(rf.write_data), .data(rf.data_to_AR)
    );
    regfile_read_port #(.BYPASS(1'b1)) u_port_b (
        .regs(regs_q), .addr(rf.read_addr_b), .wr_en(commit),
        .wr_addr(rf.write_addr), .wr_data(rf.write_data), .data(rf.data_to_BR)
    );
    regfile_read_port #(.BYPASS(1'b0)) u_port_dbg (
        .regs(regs_q), .addr(rf.dbg_addr), .wr_en(commit),
        .wr_addr(rf.write_addr), .wr_data(rf.write_data), .data(rf.dbg_data)
    );

    assign rf.write_count = write_count_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against
// an array-based reference model.
module tb_register_file;
    import register_file_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;
    word_t       model [8];
    logic [15:0] model_cnt = 16'h0;

    register_file_if rf ();
    register_file dut (.clock(clock), .reset(reset), .rf(rf));

    always #5 clock = ~clock;

    task automatic drive(input logic p, input logic w, input reg_idx_t wa, input word_t wd,
                         input reg_idx_t ra, input reg_idx_t rb, input reg_idx_t da);
        rf.p5 = p; rf.write_enable = w; rf.write_addr = wa; rf.write_data = wd;
        rf.read_addr_a = ra; rf.read_addr_b = rb; rf.dbg_addr = da;
    endtask

    // Commit to the model what the stimulus requests, then cross the edge.
    task automatic tick();
        if (reset && rf.p5 && rf.write_enable) begin
            model[rf.write_addr] = rf.write_data;
            model_cnt++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, word_t'($urandom) | 16'h1, 0, 0, 0);
        tick();
        drive(1, 1, 1, 16'hCAFE, 1, 1, 1);
        #2 reset = 1'b0;
        foreach (model[i]) model[i] = 16'h0;
        model_cnt = 16'h0;
        #1;
        total++;
        if (rf.data_to_AR !== 16'h0 || rf.data_to_BR !== 16'h0 || rf.dbg_data !== 16'h0 || rf.write_count !== 16'h0)
            $display("FAIL reset_immediate: AR=%h BR=%h dbg=%h cnt=%h required all 0000",
                     rf.data_to_AR, rf.data_to_BR, rf.dbg_data, rf.write_count);
        else passed++;
        @(posedge clock); #1;
        total++;
        if (rf.dbg_data !== 16'h0 || rf.write_count !== 16'h0)
            $display("FAIL reset_held_write: dbg=%h cnt=%h required 0000 0000", rf.dbg_data, rf.write_count);
        else passed++;
        drive(0, 0, 0, 0, 1, 1, 1);
        reset = 1'b1;
        tick();
        total++;
        if (rf.dbg_data !== 16'h0 || rf.write_count !== 16'h0)
            $display("FAIL reset_release: dbg=%h cnt=%h required 0000 0000", rf.dbg_data, rf.write_count);
        else passed++;
    endtask

    task automatic test_write_read();
        drive(1, 1, 3, 16'hBEEF, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 3, 0, 3);
        #1;
        total++;
        if (rf.data_to_AR !== 16'hBEEF) $display("FAIL write_read_AR: got %h required BEEF", rf.data_to_AR);
        else passed++;
        total++;
        if (rf.write_count !== 16'h1) $display("FAIL write_read_cnt: got %h required 0001", rf.write_count);
        else passed++;
    endtask

    task automatic test_no_write();
        logic [15:0] c0 = model_cnt;
        for (int k = 0; k < 2; k++) begin
            drive(k == 0, k == 1, 2, 16'h1234, 2, 2, 2);
            #1;
            total++;
            if (rf.data_to_AR !== 16'h0 || rf.data_to_BR !== 16'h0)
                $display("FAIL no_write_bypass%0d: AR=%h BR=%h required 0000", k, rf.data_to_AR, rf.data_to_BR);
            else passed++;
            tick();
            total++;
            if (rf.dbg_data !== 16'h0 || rf.write_count !== c0)
                $display("FAIL no_write%0d: reg2=%h cnt=%h required 0000 %h", k, rf.dbg_data, rf.write_count, c0);
            else passed++;
        end
    endtask

    task automatic test_bypass();
        drive(1, 1, 5, 16'h00A5, 5, 5, 5);
        #1;
        total++;
        if (rf.data_to_AR !== 16'h00A5 || rf.data_to_BR !== 16'h00A5)
            $display("FAIL bypass_same_cycle: AR=%h BR=%h required 00A5", rf.data_to_AR, rf.data_to_BR);
        else passed++;
        total++;
        if (rf.dbg_data !== 16'h0) $display("FAIL bypass_dbg_before: got %h required 0000", rf.dbg_data);
        else passed++;
        tick();
        drive(0, 0, 0, 0, 5, 5, 5);
        #1;
        total++;
        if (rf.dbg_data !== 16'h00A5) $display("FAIL bypass_dbg_after: got %h required 00A5", rf.dbg_data);
        else passed++;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, reg_idx_t'(i), word_t'(16'h1111 * i), 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            rf.dbg_addr = reg_idx_t'(i);
            rf.read_addr_a = reg_idx_t'(i);
            rf.read_addr_b = reg_idx_t'(7 - i);
            #1;
            total++;
            if (rf.dbg_data !== word_t'(16'h1111 * i) || rf.data_to_AR !== word_t'(16'h1111 * i)
                || rf.data_to_BR !== word_t'(16'h1111 * (7 - i)))
                $display("FAIL sweep_r%0d: dbg=%h AR=%h BR=%h required %h %h %h", i, rf.dbg_data, rf.data_to_AR,
                         rf.data_to_BR, word_t'(16'h1111 * i), word_t'(16'h1111 * i), word_t'(16'h1111 * (7 - i)));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            word_t ea, eb;
            drive(1'($urandom), 1'($urandom), reg_idx_t'($urandom), word_t'($urandom),
                  reg_idx_t'($urandom), reg_idx_t'($urandom), reg_idx_t'($urandom));
            ea = (rf.p5 && rf.write_enable && rf.read_addr_a == rf.write_addr) ? rf.write_data : model[rf.read_addr_a];
            eb = (rf.p5 && rf.write_enable && rf.read_addr_b == rf.write_addr) ? rf.write_data : model[rf.read_addr_b];
            #1;
            total++;
            if (rf.data_to_AR !== ea || rf.data_to_BR !== eb || rf.dbg_data !== model[rf.dbg_addr]
                || rf.write_count !== model_cnt)
                $display("FAIL random_%0d: AR=%h BR=%h dbg=%h cnt=%h required %h %h %h %h", n, rf.data_to_AR,
                         rf.data_to_BR, rf.dbg_data, rf.write_count, ea, eb, model[rf.dbg_addr], model_cnt);
            else passed++;
            tick();
        end
    endtask

    task automatic test_wrap();
        while (model_cnt != 16'hFFFF) begin
            drive(1, 1, reg_idx_t'($urandom), word_t'($urandom), 0, 0, 0);
            tick();
        end
        total++;
        if (rf.write_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h required FFFF", rf.write_count);
        else passed++;
        drive(1, 1, 6, 16'h5A5A, 0, 0, 6);
        tick();
        drive(0, 0, 0, 0, 0, 0, 6);
        #1;
        total++;
        if (rf.write_count !== 16'h0000 || rf.dbg_data !== 16'h5A5A)
            $display("FAIL wrap: cnt=%h reg6=%h required 0000 5A5A", rf.write_count, rf.dbg_data);
        else passed++;
    endtask

    initial begin
        foreach (model[i]) model[i] = 16'h0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        test_reset();
        test_write_read();
        test_no_write();
        test_bypass();
        test_sweep();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
